// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the page register copies DMA_LEN bytes from {page, 8'h00} into OAM.
// Build option: OAM_DMA_SRC_MIRROR_EN folds pages E0..FF onto C0..DF (echo RAM) for the source.
module oam_dma #(
  parameter logic [15:0] REG_ADDR        = 16'hFF46,
  parameter logic [15:0] OAM_BASE        = 16'hFE00,
  parameter int unsigned DMA_LEN         = 160,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_write_en,
  input  logic        reg_read_en,
  output logic [7:0]  reg_rdata,
  output logic [15:0] m_addr,
  output logic        m_read_en,
  input  logic [7:0]  m_rdata,
  output logic        m_write_en,
  output logic [7:0]  m_wdata,
  output logic        busy
);

  localparam int unsigned DLY_CYC   = START_DELAY * CYCLES_PER_BYTE;
  localparam int unsigned CNT_MAX   = (DLY_CYC > CYCLES_PER_BYTE) ? DLY_CYC : CYCLES_PER_BYTE;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned DLY_LAST  = (DLY_CYC > 0) ? DLY_CYC - 1 : 0;
  localparam int unsigned SLOT_LAST = CYCLES_PER_BYTE - 1;
  localparam int unsigned IDX_LAST  = DMA_LEN - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       page_q, page_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [15:0]      m_addr_q, m_addr_d;
  logic             m_read_en_q, m_read_en_d;
  logic             m_write_en_q, m_write_en_d;
  logic [7:0]       m_wdata_q, m_wdata_d;
  logic [7:0]       src_page;
  logic             trig;

  assign trig      = reg_write_en && (reg_addr == REG_ADDR);
  assign reg_rdata = (reg_read_en && (reg_addr == REG_ADDR)) ? page_q : 8'hFF;

  assign m_addr     = m_addr_q;
  assign m_read_en  = m_read_en_q;
  assign m_write_en = m_write_en_q;
  assign m_wdata    = m_wdata_q;
  assign busy       = busy_q;

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      page_q       <= 8'hFF;
      idx_q        <= 8'h00;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      m_addr_q     <= 16'h0000;
      m_read_en_q  <= 1'b0;
      m_write_en_q <= 1'b0;
      m_wdata_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      m_addr_q     <= m_addr_d;
      m_read_en_q  <= m_read_en_d;
      m_write_en_q <= m_write_en_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  // Next state; strobes are derived from the next state so they register in their own slot cycle
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    m_addr_d     = m_addr_q;
    m_read_en_d  = 1'b0;
    m_write_en_d = 1'b0;
    m_wdata_d    = m_read_en_q ? m_rdata : m_wdata_q;
    src_page     = 8'h00;

    case (state_q)
      S_IDLE: begin
      end
      S_DELAY: begin
        if (cnt_q == CNT_W'(DLY_LAST)) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == CNT_W'(SLOT_LAST)) begin
          cnt_d = '0;
          if (idx_q == 8'(IDX_LAST)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A page write restarts from byte 0 in any state, overriding the slot bookkeeping above
    if (trig) begin
      page_d  = reg_wdata;
      idx_d   = 8'h00;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = (START_DELAY > 0) ? S_DELAY : S_XFER;
    end

`ifdef OAM_DMA_SRC_MIRROR_EN
    src_page = (page_d >= 8'hE0) ? (page_d - 8'h20) : page_d;
`else
    src_page = page_d;
`endif

    if (state_d == S_XFER && cnt_d == CNT_W'(0)) begin
      m_read_en_d = 1'b1;
      m_addr_d    = {src_page, idx_d};
    end else if (state_d == S_XFER && cnt_d == CNT_W'(1)) begin
      m_write_en_d = 1'b1;
      m_addr_d     = OAM_BASE + {8'h00, idx_d};
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: source memory model, OAM capture and a read/write scoreboard.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_write_en;
  logic        reg_read_en;
  logic [7:0]  reg_rdata;
  logic [15:0] m_addr;
  logic        m_read_en;
  logic [7:0]  m_rdata;
  logic        m_write_en;
  logic [7:0]  m_wdata;
  logic        busy;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk          (clk),
    .reset        (reset),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_write_en (reg_write_en),
    .reg_read_en  (reg_read_en),
    .reg_rdata    (reg_rdata),
    .m_addr       (m_addr),
    .m_read_en    (m_read_en),
    .m_rdata      (m_rdata),
    .m_write_en   (m_write_en),
    .m_wdata      (m_wdata),
    .busy         (busy)
  );

  logic [7:0] src_mem [0:65535];
  logic [7:0] oam     [0:255];

  assign m_rdata = src_mem[m_addr];

  always @(posedge clk) begin
    if (m_write_en && m_addr[15:8] == 8'hFE) oam[m_addr[7:0]] <= m_wdata;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];
  int          writes_seen = 0;
  logic        prev_re = 1'b0;
  int          cyc, first_rd, k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_of(input logic [7:0] p);
`ifdef OAM_DMA_SRC_MIRROR_EN
    return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
    return p;
`endif
  endfunction

  // Per-cycle bus monitor, popping the scoreboard on every strobe
  task automatic monitor();
    logic [15:0] ea;
    logic [23:0] ew;
    chk("rd_wr_excl", 32'(m_read_en & m_write_en), 32'(0));
    if (m_read_en) begin
      chk("rd_pending", 32'(rd_q.size() > 0), 32'(1));
      if (rd_q.size() > 0) begin
        ea = rd_q.pop_front();
        chk("rd_addr", 32'(m_addr), 32'(ea));
      end
    end
    if (m_write_en) begin
      chk("wr_slot1", 32'(prev_re), 32'(1));
      chk("wr_pending", 32'(wr_q.size() > 0), 32'(1));
      if (wr_q.size() > 0) begin
        ew = wr_q.pop_front();
        chk("wr_addr", 32'(m_addr), 32'(ew[23:8]));
        chk("wr_data", 32'(m_wdata), 32'(ew[7:0]));
      end
      writes_seen++;
    end
    prev_re = m_read_en;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic check_reg(input logic [15:0] a, input logic en, input logic [7:0] exp, input string tag);
    #1;
    reg_addr    = a;
    reg_read_en = en;
    #1;
    chk(tag, 32'(reg_rdata), 32'(exp));
    reg_read_en = 1'b0;
  endtask

  // Called just after a negedge; returns at the negedge following the trigger edge
  task automatic fire(input logic [7:0] page);
    logic [7:0]  sp;
    logic [15:0] sa;
    logic [15:0] da;
    #1;
    reg_addr     = 16'hFF46;
    reg_wdata    = page;
    reg_write_en = 1'b1;
    rd_q.delete();
    wr_q.delete();
    writes_seen = 0;
    sp = src_of(page);
    for (int i = 0; i < 160; i++) begin
      sa = {sp, 8'(i)};
      da = 16'hFE00 + 16'(i);
      rd_q.push_back(sa);
      wr_q.push_back({da, src_mem[sa]});
    end
    tick();
    reg_write_en = 1'b0;
  endtask

  task automatic measure(output int n, output int first);
    n = 0;
    first = -1;
    while (busy && n < 2000) begin
      if (m_read_en && first < 0) first = n;
      n++;
      tick();
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_busy_len"}, 32'(cyc), 32'(644));
    chk({tag, "_first_rd"}, 32'(first_rd), 32'(4));
    chk({tag, "_rd_left"}, 32'(rd_q.size()), 32'(0));
    chk({tag, "_wr_left"}, 32'(wr_q.size()), 32'(0));
  endtask

  initial begin
    reset        = 1'b1;
    reg_addr     = 16'h0000;
    reg_wdata    = 8'h00;
    reg_write_en = 1'b0;
    reg_read_en  = 1'b0;
    for (int a = 0; a < 65536; a++) src_mem[a] = 8'(a * 7 + 3);
    for (int i = 0; i < 256; i++) begin
      src_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      src_mem[16'hC200 + 16'(i)] = 8'(i) ^ 8'hA5;
      src_mem[16'hC300 + 16'(i)] = 8'(i) ^ 8'h33;
      src_mem[16'hE300 + 16'(i)] = 8'(i) ^ 8'h77;
    end

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rd_en", 32'(m_read_en), 32'(0));
    chk("rst_wr_en", 32'(m_write_en), 32'(0));
    chk("rst_addr", 32'(m_addr), 32'(0));
    chk("rst_wdata", 32'(m_wdata), 32'(0));
    check_reg(16'hFF46, 1'b1, 8'hFF, "rst_page");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Basic transfer from page C1
    fire(8'hC1);
    measure(cyc, first_rd);
    check_done("xfer_c1");
    for (int i = 0; i < 160; i++) chk("oam_c1", 32'(oam[i]), 32'(8'(i) ^ 8'h5A));

    // Register readback and stray accesses
    check_reg(16'hFF46, 1'b1, 8'hC1, "rd_page");
    check_reg(16'h1234, 1'b1, 8'hFF, "rd_other");
    check_reg(16'hFF46, 1'b0, 8'hFF, "rd_noen");
    #1;
    reg_addr     = 16'hFF47;
    reg_wdata    = 8'h55;
    reg_write_en = 1'b1;
    tick();
    reg_write_en = 1'b0;
    tick();
    chk("stray_busy", 32'(busy), 32'(0));
    check_reg(16'hFF46, 1'b1, 8'hC1, "stray_page");

    // Retrigger mid-transfer with page C2
    fire(8'hC1);
    k = 0;
    while (writes_seen < 50 && k < 3000) begin
      tick();
      k++;
    end
    chk("wait50", 32'(writes_seen), 32'(50));
    fire(8'hC2);
    measure(cyc, first_rd);
    check_done("retrig_c2");
    for (int i = 0; i < 160; i++) chk("oam_c2", 32'(oam[i]), 32'(8'(i) ^ 8'hA5));

    // Reset in the middle of byte 79's slot, before byte 80 is read
    fire(8'hC3);
    check_reg(16'hFF46, 1'b1, 8'hC3, "rd_busy");
    k = 0;
    while (writes_seen < 80 && k < 3000) begin
      tick();
      k++;
    end
    chk("wait80", 32'(writes_seen), 32'(80));
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_rd_en", 32'(m_read_en), 32'(0));
    chk("mid_rst_wr_en", 32'(m_write_en), 32'(0));
    rd_q.delete();
    wr_q.delete();
    tick();
    tick();
    tick();
    reset = 1'b0;
    repeat (60) tick();
    chk("post_rst_busy", 32'(busy), 32'(0));
    for (int i = 0; i < 80; i++) chk("oam_c3_part", 32'(oam[i]), 32'(8'(i) ^ 8'h33));
    for (int i = 80; i < 160; i++) chk("oam_kept", 32'(oam[i]), 32'(8'(i) ^ 8'hA5));
    check_reg(16'hFF46, 1'b1, 8'hFF, "post_rst_page");

    // Echo page E3
    fire(8'hE3);
    measure(cyc, first_rd);
    check_done("xfer_e3");
    check_reg(16'hFF46, 1'b1, 8'hE3, "rd_e3");
    for (int i = 0; i < 160; i++) begin
`ifdef OAM_DMA_SRC_MIRROR_EN
      chk("oam_e3", 32'(oam[i]), 32'(8'(i) ^ 8'h33));
`else
      chk("oam_e3", 32'(oam[i]), 32'(8'(i) ^ 8'h77));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
